// File: rtl/icosoc_mod_ps2_fifo.sv
// icosoc_mod_ps2_fifo: PS/2 deframer, scan-code FIFO and ctrl-bus registers.
// Define PS2_TX_EN to build the host-to-device command transmitter.
module icosoc_mod_ps2_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int INHIBIT_CYCLES = 1200
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [15:0] ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic        ps2_clk_oe,
  output logic        ps2_dat_oe
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {R_IDLE, R_SHIFT} rx_st_t;

  logic clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FILTER_LEN-1:0] filt;
  logic fclk;
  logic edge_ev;

  logic tx_busy, tx_timed, rx_hold, nak_set;

  // pin synchronisers and clock glitch filter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      filt   <= '1;
      fclk   <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_i;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat_i;
      dat_s2 <= dat_s1;
      filt   <= {filt[FILTER_LEN-2:0], clk_s2};
      if (&filt)
        fclk <= 1'b1;
      else if (~|filt)
        fclk <= 1'b0;
    end
  end

  assign edge_ev = fclk & ~|filt;

  // shared inactivity timer, restarted on every clock edge
  logic [TW-1:0] tmo_cnt;
  logic tmo_run, tmo;
  rx_st_t rx_st, rx_nxt;

  assign tmo_run = (rx_st == R_SHIFT) | tx_timed;
  assign tmo = tmo_run & ~edge_ev & (tmo_cnt == TMO_MAX);

  // timeout counter
  always_ff @(posedge clk) begin
    if (!resetn)
      tmo_cnt <= '0;
    else if (edge_ev | ~tmo_run)
      tmo_cnt <= '0;
    else if (tmo_cnt != TMO_MAX)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  logic [3:0] rx_cnt, rx_cnt_n;
  logic [7:0] rx_sr, rx_sr_n;
  logic rx_par, rx_par_n;
  logic rx_push, perr_set, ferr_set;

  // RX state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_st  <= R_IDLE;
      rx_cnt <= '0;
      rx_sr  <= '0;
      rx_par <= 1'b0;
    end else begin
      rx_st  <= rx_nxt;
      rx_cnt <= rx_cnt_n;
      rx_sr  <= rx_sr_n;
      rx_par <= rx_par_n;
    end
  end

  // RX next state: start, 8 data, parity, stop
  always_comb begin
    rx_nxt   = rx_st;
    rx_cnt_n = rx_cnt;
    rx_sr_n  = rx_sr;
    rx_par_n = rx_par;
    rx_push  = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    unique case (rx_st)
      R_IDLE: begin
        if (edge_ev & ~dat_s2 & ~rx_hold) begin
          rx_nxt   = R_SHIFT;
          rx_cnt_n = '0;
        end
      end
      R_SHIFT: begin
        if (rx_hold) begin
          rx_nxt = R_IDLE;
        end else if (edge_ev) begin
          if (rx_cnt < 4'd8) begin
            rx_sr_n  = {dat_s2, rx_sr[7:1]};
            rx_cnt_n = rx_cnt + 4'd1;
          end else if (rx_cnt == 4'd8) begin
            rx_par_n = dat_s2;
            rx_cnt_n = 4'd9;
          end else begin
            rx_nxt = R_IDLE;
            if (!dat_s2)
              ferr_set = 1'b1;
            else if (!(^{rx_sr, rx_par}))
              perr_set = 1'b1;
            else
              rx_push = 1'b1;
          end
        end else if (tmo) begin
          ferr_set = 1'b1;
          rx_nxt   = R_IDLE;
        end
      end
    endcase
  end

  logic [7:0] mem [FIFO_DEPTH];
  logic [LW-1:0] wptr, rptr, level;
  logic full, empty, do_push, do_pop;

  assign level   = wptr - rptr;
  assign full    = level == LW'(FIFO_DEPTH);
  assign empty   = level == '0;
  assign do_push = rx_push & ~full;

  // FIFO storage
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr[AW-1:0]] <= rx_sr;
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (do_pop)
        rptr <= rptr + 1'b1;
    end
  end

  logic req, wr_req, a_data, a_stat, clr;
  logic ovf, perr, ferr, tx_nak;
  logic [7:0] lvl8;
  logic [31:0] status, rd_mux;

  assign req    = ~ctrl_done & (ctrl_rd | (|ctrl_wr));
  assign wr_req = req & (|ctrl_wr);
  assign a_data = ctrl_addr == 16'h0000;
  assign a_stat = ctrl_addr == 16'h0004;
  assign do_pop = req & ctrl_rd & a_data & ~empty;
  assign clr    = wr_req & a_stat;
  assign lvl8   = 8'(level);
  assign status = {19'h0, tx_nak, tx_busy, ferr, perr, ovf, lvl8};

  // read data mux
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      a_data:  rd_mux = empty ? 32'hFFFF_FFFF : {24'h0, mem[rptr[AW-1:0]]};
      a_stat:  rd_mux = status;
      default: rd_mux = '0;
    endcase
  end

  // one-cycle acknowledge with registered read data
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_done <= 1'b0;
      ctrl_rdat <= '0;
    end else if (req) begin
      ctrl_done <= 1'b1;
      ctrl_rdat <= ctrl_rd ? rd_mux : '0;
    end else begin
      ctrl_done <= 1'b0;
      ctrl_rdat <= '0;
    end
  end

  // sticky status bits, set beats clear
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf    <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      tx_nak <= 1'b0;
    end else begin
      if (rx_push & full)
        ovf <= 1'b1;
      else if (clr & ctrl_wdat[8])
        ovf <= 1'b0;
      if (perr_set)
        perr <= 1'b1;
      else if (clr & ctrl_wdat[9])
        perr <= 1'b0;
      if (ferr_set)
        ferr <= 1'b1;
      else if (clr & ctrl_wdat[10])
        ferr <= 1'b0;
      if (nak_set)
        tx_nak <= 1'b1;
      else if (clr & ctrl_wdat[12])
        tx_nak <= 1'b0;
    end
  end

`ifdef PS2_TX_EN
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [IW-1:0] INH_MAX = IW'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {
    T_IDLE, T_INH, T_REQ, T_SEND, T_ACK, T_WREL
  } tx_st_t;

  tx_st_t tx_st, tx_nxt;
  logic [IW-1:0] tx_cnt, tx_cnt_n;
  logic [3:0] tx_bit, tx_bit_n;
  logic [8:0] tx_sr, tx_sr_n;
  logic coe_q, doe_q, coe_n, doe_n;
  logic tx_wr;

  assign tx_wr = wr_req & a_data & (tx_st == T_IDLE);

  // TX state register and registered line enables
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_st  <= T_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sr  <= '0;
      coe_q  <= 1'b0;
      doe_q  <= 1'b0;
    end else begin
      tx_st  <= tx_nxt;
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_sr  <= tx_sr_n;
      coe_q  <= coe_n;
      doe_q  <= doe_n;
    end
  end

  // TX next state: inhibit, request, 8 data + parity, stop, ack
  always_comb begin
    tx_nxt   = tx_st;
    tx_cnt_n = tx_cnt;
    tx_bit_n = tx_bit;
    tx_sr_n  = tx_sr;
    coe_n    = 1'b0;
    doe_n    = doe_q;
    nak_set  = 1'b0;
    unique case (tx_st)
      T_IDLE: begin
        doe_n = 1'b0;
        if (tx_wr) begin
          tx_nxt   = T_INH;
          tx_cnt_n = '0;
          tx_sr_n  = {~^ctrl_wdat[7:0], ctrl_wdat[7:0]};
          coe_n    = 1'b1;
        end
      end
      T_INH: begin
        coe_n = 1'b1;
        if (tx_cnt == INH_MAX) begin
          tx_nxt = T_REQ;
          coe_n  = 1'b0;
          doe_n  = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      T_REQ: begin
        if (edge_ev) begin
          doe_n    = ~tx_sr[0];
          tx_sr_n  = {1'b0, tx_sr[8:1]};
          tx_bit_n = 4'd1;
          tx_nxt   = T_SEND;
        end else if (tmo) begin
          doe_n   = 1'b0;
          nak_set = 1'b1;
          tx_nxt  = T_IDLE;
        end
      end
      T_SEND: begin
        if (edge_ev) begin
          if (tx_bit == 4'd9) begin
            doe_n  = 1'b0;
            tx_nxt = T_ACK;
          end else begin
            doe_n    = ~tx_sr[0];
            tx_sr_n  = {1'b0, tx_sr[8:1]};
            tx_bit_n = tx_bit + 4'd1;
          end
        end else if (tmo) begin
          doe_n   = 1'b0;
          nak_set = 1'b1;
          tx_nxt  = T_IDLE;
        end
      end
      T_ACK: begin
        if (edge_ev) begin
          nak_set = dat_s2;
          tx_nxt  = T_WREL;
        end else if (tmo) begin
          doe_n   = 1'b0;
          nak_set = 1'b1;
          tx_nxt  = T_IDLE;
        end
      end
      T_WREL: begin
        doe_n = 1'b0;
        if (fclk & dat_s2)
          tx_nxt = T_IDLE;
      end
      default: begin
        doe_n  = 1'b0;
        tx_nxt = T_IDLE;
      end
    endcase
  end

  assign tx_busy    = tx_st != T_IDLE;
  assign tx_timed   = (tx_st == T_REQ) | (tx_st == T_SEND) |
                      (tx_st == T_ACK);
  assign rx_hold    = tx_busy;
  assign ps2_clk_oe = coe_q;
  assign ps2_dat_oe = doe_q;
`else
  assign tx_busy    = 1'b0;
  assign tx_timed   = 1'b0;
  assign rx_hold    = 1'b0;
  assign nak_set    = 1'b0;
  assign ps2_clk_oe = 1'b0;
  assign ps2_dat_oe = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, ctrl_wdat};

endmodule

// File: tb/tb_icosoc_mod_ps2_fifo.sv
// tb_icosoc_mod_ps2_fifo: frame vectors, FIFO scoreboard, TX device model.
// TX sequences are built when PS2_TX_EN is defined.
module tb_icosoc_mod_ps2_fifo;

  localparam int FD  = 8;
  localparam int FL  = 4;
  localparam int TMO = 400;
  localparam int INH = 50;
  localparam int H   = 20;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  ctrl_wr = '0;
  logic        ctrl_rd = 1'b0;
  logic [15:0] ctrl_addr = '0;
  logic [31:0] ctrl_wdat = '0;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;
  logic        ps2_clk_i, ps2_dat_i;
  logic        ps2_clk_oe, ps2_dat_oe;
  logic        dev_clk = 1'b1;
  logic        dev_dat = 1'b1;

  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

  icosoc_mod_ps2_fifo #(
    .FIFO_DEPTH(FD), .FILTER_LEN(FL),
    .TIMEOUT_CYCLES(TMO), .INHIBIT_CYCLES(INH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd),
    .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat),
    .ctrl_rdat(ctrl_rdat), .ctrl_done(ctrl_done),
    .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q [$];
  bit m_ovf, m_perr, m_ferr;

  typedef struct {
    logic [7:0]  b;
    bit          bp;
    bit          bs;
    logic [31:0] st;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    ctrl_addr = a;
    ctrl_rd = 1'b1;
    @(negedge clk);
    ctrl_rd = 1'b0;
    check("rd_done", 32'(ctrl_done), 32'd1);
    d = ctrl_rdat;
    @(negedge clk);
    check("rd_done_low", {31'h0, ctrl_done}, 32'd0);
    check("rdat_idle", ctrl_rdat, 32'd0);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] w);
    @(negedge clk);
    ctrl_addr = a;
    ctrl_wdat = w;
    ctrl_wr = 4'hF;
    @(negedge clk);
    ctrl_wr = 4'h0;
    check("wr_done", 32'(ctrl_done), 32'd1);
  endtask

  function automatic logic [31:0] exp_st();
    return {19'h0, 2'b00, m_ferr, m_perr, m_ovf, 8'(exp_q.size())};
  endfunction

  task automatic rd_data_chk(input string name);
    logic [31:0] d, e;
    bus_rd(16'h0, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    check(name, d, e);
  endtask

  task automatic st_chk(input string name, input logic [31:0] e);
    logic [31:0] d;
    bus_rd(16'h4, d);
    check(name, d, e);
  endtask

  task automatic ps2_frame(input logic [7:0] b, input bit bp,
                           input bit bs, input int nb);
    logic [10:0] f;
    f = {~bs, (~^b) ^ bp, b, 1'b0};
    for (int i = 0; i < nb; i++) begin
      dev_dat = f[i];
      wait_cyc(H);
      dev_clk = 1'b0;
      wait_cyc(H);
      dev_clk = 1'b1;
    end
    wait_cyc(H);
    dev_dat = 1'b1;
    wait_cyc(H);
  endtask

  task automatic frame(input logic [7:0] b, input bit bp, input bit bs);
    ps2_frame(b, bp, bs, 11);
    if (bs)
      m_ferr = 1'b1;
    else if (bp)
      m_perr = 1'b1;
    else if (exp_q.size() < FD)
      exp_q.push_back({24'h0, b});
    else
      m_ovf = 1'b1;
  endtask

`ifdef PS2_TX_EN
  task automatic tx_run(input logic [7:0] b, input bit ack);
    int n;
    logic [9:0] got;
    logic [31:0] d;
    got = '0;
    bus_wr(16'h0, {24'h0, b});
    n = 0;
    while (ps2_clk_oe && n < 4 * INH) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("start_drv", {30'h0, ps2_clk_oe, ps2_dat_oe}, 32'd1);
    wait_cyc(H);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack)
        dev_dat = 1'b0;
      dev_clk = 1'b0;
      wait_cyc(H);
      dev_clk = 1'b1;
      if (k <= 10)
        got[k-1] = ps2_dat_i;
      wait_cyc(H);
    end
    dev_dat = 1'b1;
    check("tx_byte", 32'(got[7:0]), 32'(b));
    check("tx_parity", 32'(got[8]), 32'(~^b));
    check("tx_stop", 32'(got[9]), 32'd1);
    n = 0;
    d = '1;
    while (n < 60) begin
      bus_rd(16'h4, d);
      n++;
      if (!d[11])
        break;
    end
    check("tx_busy_clear", 32'(d[11]), 32'd0);
    check("tx_nak", 32'(d[12]), ack ? 32'd0 : 32'd1);
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    tbl[0] = '{8'h1C, 1'b0, 1'b0, 32'h0000_0001};
    tbl[1] = '{8'hA5, 1'b1, 1'b0, 32'h0000_0201};
    tbl[2] = '{8'h33, 1'b0, 1'b1, 32'h0000_0601};
    tbl[3] = '{8'hF0, 1'b0, 1'b0, 32'h0000_0602};

    wait_cyc(5);
    check("rst_done", 32'(ctrl_done), 32'd0);
    check("rst_rdat", ctrl_rdat, 32'd0);
    check("rst_oe", {30'h0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    resetn = 1'b1;
    wait_cyc(2);
    st_chk("rst_status", 32'h0);

    frame(8'h1C, 1'b0, 1'b0);
    rd_data_chk("first_byte");
    rd_data_chk("empty_read");
    st_chk("status_after_1c", 32'h0);

    for (int i = 0; i < 4; i++) begin
      frame(tbl[i].b, tbl[i].bp, tbl[i].bs);
      st_chk($sformatf("tbl%0d_status", i), tbl[i].st);
    end
    bus_wr(16'h4, 32'h0000_0700);
    m_perr = 1'b0;
    m_ferr = 1'b0;
    st_chk("w1c_errs", 32'h0000_0002);
    for (int i = 0; i < 3; i++)
      rd_data_chk($sformatf("tbl_drain%0d", i));

    for (int i = 1; i <= FD + 1; i++)
      frame(8'(i), 1'b0, 1'b0);
    st_chk("ovf_status", exp_st());
    check("ovf_expect", exp_st(), 32'h0000_0108);

    @(negedge clk);
    ctrl_addr = 16'h0;
    ctrl_rd = 1'b1;
    @(negedge clk);
    check("hold_rd_done", 32'(ctrl_done), 32'd1);
    check("hold_rd_data", ctrl_rdat, exp_q.pop_front());
    @(negedge clk);
    ctrl_rd = 1'b0;
    check("hold_rd_gap", 32'(ctrl_done), 32'd0);
    st_chk("hold_rd_level", exp_st());

    for (int i = 0; i < FD; i++)
      rd_data_chk($sformatf("ovf_drain%0d", i));
    bus_wr(16'h4, 32'h0000_0100);
    m_ovf = 1'b0;
    st_chk("ovf_cleared", 32'h0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dev_dat = 1'b0;
      dev_clk = 1'b0;
      wait_cyc(FL - 1);
      dev_clk = 1'b1;
      wait_cyc(10);
      dev_dat = 1'b1;
      wait_cyc(10);
    end
    st_chk("glitch_ignored", 32'h0);

    ps2_frame(8'h77, 1'b0, 1'b0, 5);
    wait_cyc(TMO);
    st_chk("timeout_ferr", 32'h0000_0400);
    bus_wr(16'h4, 32'h0000_0400);
    frame(8'h5A, 1'b0, 1'b0);
    st_chk("post_timeout_status", 32'h0000_0001);
    rd_data_chk("post_timeout_byte");

    bus_rd(16'h0008, d);
    check("unmapped_read", d, 32'h0);
    bus_wr(16'h0008, 32'hFFFF_FFFF);
    st_chk("unmapped_write", 32'h0);

    dev_dat = 1'b0;
    wait_cyc(H);
    dev_clk = 1'b0;
    wait_cyc(H);
    dev_clk = 1'b1;
    wait_cyc(H);
    dev_dat = 1'b1;
    resetn = 1'b0;
    wait_cyc(2);
    resetn = 1'b1;
    st_chk("midframe_rst_status", 32'h0);
    rd_data_chk("midframe_rst_empty");
    frame(8'h3C, 1'b0, 1'b0);
    rd_data_chk("post_rst_byte");

`ifdef PS2_TX_EN
    tx_run(8'hED, 1'b1);
    tx_run(8'hED, 1'b0);
    bus_wr(16'h4, 32'h0000_1000);
    st_chk("nak_cleared", 32'h0);
    bus_wr(16'h0, 32'h0000_0055);
    wait_cyc(10);
    resetn = 1'b0;
    @(negedge clk);
    check("tx_rst_oe", {30'h0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    resetn = 1'b1;
    st_chk("tx_rst_status", 32'h0);
    rd_data_chk("tx_rst_empty");
`else
    bus_wr(16'h0, 32'h0000_00ED);
    wait_cyc(INH + 20);
    check("no_tx_oe", {30'h0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    st_chk("no_tx_status", 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
